lfsr_run_stats: RTL and testbench

LFSR_RUN_STATS -- requirements
Module: lfsr_run_stats

---
 rtl/lfsr_run_stats_pkg.sv | 11 +
 rtl/lfsr_run_stats_if.sv | 27 ++
 rtl/lfsr_run_stats_run_tracker.sv | 91 +++++++++
 rtl/lfsr_run_stats.sv | 123 ++++++++++++
 tb/tb_lfsr_run_stats.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_run_stats_pkg.sv
// Shared types and defaults for the LFSR run-statistics block.
package lfsr_run_stats_pkg;

    localparam int unsigned CwDefault = 20;

    typedef enum logic [0:0] {
        StArm     = 1'b0,
        StMeasure = 1'b1
    } state_e;

endpackage

// File: rtl/lfsr_run_stats_if.sv
// Sample/handshake bundle between an upstream LFSR, the stats block and its consumer.
interface lfsr_run_stats_if
    import lfsr_run_stats_pkg::*;
#(
    parameter int unsigned CW = CwDefault
);
    logic          sh_en;
    logic          msb;
    logic          max_tick;
    logic          res_ready;
    logic          res_valid;
    logic          overrun;
    logic [CW-1:0] run_count;
    logic [CW-1:0] longest_one;
    logic [CW-1:0] longest_zero;
    logic [CW-1:0] period_len;

    modport master (
        output sh_en, msb, max_tick, res_ready,
        input  res_valid, overrun, run_count, longest_one, longest_zero, period_len
    );

    modport slave (
        input  sh_en, msb, max_tick, res_ready,
        output res_valid, overrun, run_count, longest_one, longest_zero, period_len
    );
endinterface

// File: rtl/lfsr_run_stats_run_tracker.sv
// Tracks the current run and the longest 1/0 runs seen so far in a period.
module lfsr_run_stats_run_tracker
    import lfsr_run_stats_pkg::*;
#(
    parameter int unsigned CW = CwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample,
    input  logic          first,
    input  logic          bit_in,
    input  logic          close,
    output logic [1:0]    run_ends,
    output logic [CW-1:0] longest_one,
    output logic [CW-1:0] longest_zero
);
    logic [CW-1:0] cur_len_q, cur_len_d, len_b;
    logic [CW-1:0] lo_q, lo_d, lo_a;
    logic [CW-1:0] lz_q, lz_d, lz_a;
    logic          prev_bit_q, prev_bit_d;
    logic          change;

    always_comb begin
        change = !first && (bit_in != prev_bit_q);

        // Longest values after closing the run that this bit terminates.
        lo_a = lo_q;
        lz_a = lz_q;
        if (change) begin
            if (prev_bit_q) begin
                if (cur_len_q > lo_q) lo_a = cur_len_q;
            end else if (cur_len_q > lz_q) begin
                lz_a = cur_len_q;
            end
        end

        if (first || change) begin
            len_b = CW'(1);
        end else if (cur_len_q == {CW{1'b1}}) begin
            len_b = cur_len_q;
        end else begin
            len_b = cur_len_q + CW'(1);
        end

        // On the end-of-period bit the run holding this bit is closed as well.
        longest_one  = lo_a;
        longest_zero = lz_a;
        if (close) begin
            if (bit_in) begin
                if (len_b > lo_a) longest_one = len_b;
            end else if (len_b > lz_a) begin
                longest_zero = len_b;
            end
        end

        run_ends = {1'b0, change} + {1'b0, close};

        cur_len_d  = cur_len_q;
        prev_bit_d = prev_bit_q;
        lo_d       = lo_q;
        lz_d       = lz_q;
        if (sample) begin
            if (close) begin
                cur_len_d  = '0;
                prev_bit_d = 1'b0;
                lo_d       = '0;
                lz_d       = '0;
            end else begin
                cur_len_d  = len_b;
                prev_bit_d = bit_in;
                lo_d       = lo_a;
                lz_d       = lz_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_len_q  <= '0;
            prev_bit_q <= 1'b0;
            lo_q       <= '0;
            lz_q       <= '0;
        end else begin
            cur_len_q  <= cur_len_d;
            prev_bit_q <= prev_bit_d;
            lo_q       <= lo_d;
            lz_q       <= lz_d;
        end
    end

endmodule

// File: rtl/lfsr_run_stats.sv
// Measures run statistics over each LFSR period and publishes them through a valid/ready hold.
module lfsr_run_stats
    import lfsr_run_stats_pkg::*;
#(
    parameter int unsigned CW = CwDefault
) (
    input logic             clk,
    input logic             rst,
    lfsr_run_stats_if.slave bus
);
    state_e        state_q, state_d;
    logic          first_q, first_d;
    logic [CW-1:0] runs_q, runs_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] run_count_q, run_count_d;
    logic [CW-1:0] longest_one_q, longest_one_d;
    logic [CW-1:0] longest_zero_q, longest_zero_d;
    logic [CW-1:0] period_len_q, period_len_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    logic          sample, close;
    logic [1:0]    run_ends;
    logic [CW-1:0] longest_one_nx, longest_zero_nx;
    logic [CW-1:0] len_sum, runs_sum;
    logic [CW:0]   runs_wide;

    assign sample = bus.sh_en && (state_q == StMeasure);
    assign close  = sample && bus.max_tick;

    lfsr_run_stats_run_tracker #(
        .CW (CW)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .first        (first_q),
        .bit_in       (bus.msb),
        .close        (close),
        .run_ends     (run_ends),
        .longest_one  (longest_one_nx),
        .longest_zero (longest_zero_nx)
    );

    always_comb begin
        len_sum   = (len_q == {CW{1'b1}}) ? len_q : len_q + CW'(1);
        runs_wide = {1'b0, runs_q} + {{(CW - 1){1'b0}}, run_ends};
        runs_sum  = runs_wide[CW] ? {CW{1'b1}} : runs_wide[CW-1:0];

        state_d        = state_q;
        first_d        = first_q;
        runs_d         = runs_q;
        len_d          = len_q;
        run_count_d    = run_count_q;
        longest_one_d  = longest_one_q;
        longest_zero_d = longest_zero_q;
        period_len_d   = period_len_q;

        unique case (state_q)
            StArm: begin
                if (bus.sh_en && bus.max_tick) state_d = StMeasure;
            end
            StMeasure: begin
                if (sample) begin
                    first_d = close;
                    runs_d  = close ? '0 : runs_sum;
                    len_d   = close ? '0 : len_sum;
                end
            end
        endcase

        if (close) begin
            run_count_d    = runs_sum;
            longest_one_d  = longest_one_nx;
            longest_zero_d = longest_zero_nx;
            period_len_d   = len_sum;
        end

        // A fresh publication always wins over a same-cycle acknowledge.
        if (close) begin
            valid_d = 1'b1;
        end else if (bus.res_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        overrun_d = overrun_q | (close & valid_q & ~bus.res_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StArm;
            first_q        <= 1'b1;
            runs_q         <= '0;
            len_q          <= '0;
            run_count_q    <= '0;
            longest_one_q  <= '0;
            longest_zero_q <= '0;
            period_len_q   <= '0;
            valid_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            runs_q         <= runs_d;
            len_q          <= len_d;
            run_count_q    <= run_count_d;
            longest_one_q  <= longest_one_d;
            longest_zero_q <= longest_zero_d;
            period_len_q   <= period_len_d;
            valid_q        <= valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign bus.res_valid    = valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.run_count    = run_count_q;
    assign bus.longest_one  = longest_one_q;
    assign bus.longest_zero = longest_zero_q;
    assign bus.period_len   = period_len_q;

endmodule

// File: tb/tb_lfsr_run_stats.sv
// Randomized and directed checks of lfsr_run_stats against a per-period bit-queue model.
module tb_lfsr_run_stats;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lfsr_run_stats_if #(.CW(20)) bus ();
    lfsr_run_stats_if #(.CW(3))  bus_s ();

    assign bus_s.sh_en     = bus.sh_en;
    assign bus_s.msb       = bus.msb;
    assign bus_s.max_tick  = bus.max_tick;
    assign bus_s.res_ready = bus.res_ready;

    lfsr_run_stats #(.CW(20)) dut (.clk(clk), .rst(rst), .bus(bus));
    lfsr_run_stats #(.CW(3))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: bits of the period in progress, last published (unsaturated) stats.
    bit                q[$];
    bit                measuring = 1'b0;
    longint unsigned   e_runs = 0, e_lo = 0, e_lz = 0, e_len = 0;
    bit                e_valid = 1'b0, e_ovr = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
            if (errors >= 100) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    function automatic logic [63:0] sat(input longint unsigned v, input int unsigned w);
        longint unsigned m = (64'd1 << w) - 64'd1;
        return (v > m) ? m : v;
    endfunction

    task automatic model_publish();
        longint unsigned run = 0;
        e_runs = 0;
        e_lo   = 0;
        e_lz   = 0;
        e_len  = longint'(q.size());
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0 || q[i] != q[i-1]) begin
                e_runs++;
                run = 1;
            end else begin
                run++;
            end
            if (q[i] && run > e_lo) e_lo = run;
            if (!q[i] && run > e_lz) e_lz = run;
        end
    endtask

    task automatic model_step();
        bit pub = 1'b0;
        if (rst) begin
            measuring = 1'b0;
            q.delete();
            e_runs = 0; e_lo = 0; e_lz = 0; e_len = 0;
            e_valid = 1'b0;
            e_ovr   = 1'b0;
        end else begin
            if (bus.sh_en) begin
                if (!measuring) begin
                    if (bus.max_tick) measuring = 1'b1;
                end else begin
                    q.push_back(bus.msb);
                    if (bus.max_tick) begin
                        pub = 1'b1;
                        model_publish();
                        q.delete();
                    end
                end
            end
            if (pub) begin
                if (e_valid && !bus.res_ready) e_ovr = 1'b1;
                e_valid = 1'b1;
            end else if (bus.res_ready) begin
                e_valid = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("res_valid", 64'(bus.res_valid), 64'(e_valid));
        check("overrun", 64'(bus.overrun), 64'(e_ovr));
        check("run_count", 64'(bus.run_count), sat(e_runs, 20));
        check("longest_one", 64'(bus.longest_one), sat(e_lo, 20));
        check("longest_zero", 64'(bus.longest_zero), sat(e_lz, 20));
        check("period_len", 64'(bus.period_len), sat(e_len, 20));
        check("s_res_valid", 64'(bus_s.res_valid), 64'(e_valid));
        check("s_overrun", 64'(bus_s.overrun), 64'(e_ovr));
        check("s_run_count", 64'(bus_s.run_count), sat(e_runs, 3));
        check("s_longest_one", 64'(bus_s.longest_one), sat(e_lo, 3));
        check("s_longest_zero", 64'(bus_s.longest_zero), sat(e_lz, 3));
        check("s_period_len", 64'(bus_s.period_len), sat(e_len, 3));
    end

    task automatic drive(input logic sh, input logic m, input logic mt, input logic rdy);
        bus.sh_en     = sh;
        bus.msb       = m;
        bus.max_tick  = mt;
        bus.res_ready = rdy;
        @(negedge clk);
    endtask

    // Drives n bits of pat MSB-first, max_tick on the last, optional sh_en=0 gaps.
    task automatic period(input logic [15:0] pat, input int n, input logic rdy_last,
                          input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) drive(1'b0, 1'($urandom), 1'($urandom), 1'b0);
            end
            drive(1'b1, pat[i], i == 0, (i == 0) ? rdy_last : 1'b0);
        end
    endtask

    task automatic lit(input string tag, input logic [63:0] rc, input logic [63:0] lo,
                       input logic [63:0] lz, input logic [63:0] len, input logic [63:0] vld,
                       input logic [63:0] ovr);
        check({tag, "_run_count"}, 64'(bus.run_count), rc);
        check({tag, "_longest_one"}, 64'(bus.longest_one), lo);
        check({tag, "_longest_zero"}, 64'(bus.longest_zero), lz);
        check({tag, "_period_len"}, 64'(bus.period_len), len);
        check({tag, "_res_valid"}, 64'(bus.res_valid), vld);
        check({tag, "_overrun"}, 64'(bus.overrun), ovr);
    endtask

    initial begin
        logic [18:0] st;
        int          ticks;
        logic        mt;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        lit("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Arm, then 1,1,0,0,0,1 with max_tick on the last bit.
        drive(1'b1, 1'($urandom), 1'b1, 1'b0);
        period(16'b110001, 6, 1'b0, 1'b0);
        lit("direct", 3, 2, 3, 6, 1, 0);

        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_drops_valid", 64'(bus.res_valid), 64'd0);

        // Same period with random sh_en=0 gaps carrying random msb/max_tick.
        period(16'b110001, 6, 1'b0, 1'b1);
        lit("gapped", 3, 2, 3, 6, 1, 0);

        // Second publication without acknowledge overwrites and flags overrun.
        period(16'b010, 3, 1'b0, 1'b0);
        lit("overrun", 3, 1, 1, 3, 1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        lit("overrun_sticky", 3, 1, 1, 3, 0, 1);

        // Reset mid-period, then a max_tick that only re-arms.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        lit("mid_reset", 0, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        lit("rearm_only", 0, 0, 0, 0, 0, 0);
        period(16'b110001, 6, 1'b0, 1'b0);
        lit("after_rearm", 3, 2, 3, 6, 1, 0);

        // Publication coinciding with acknowledge.
        period(16'b100111, 6, 1'b1, 1'b0);
        lit("pub_with_ack", 3, 3, 2, 6, 1, 0);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) == 0));
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // 19-bit maximal LFSR; max_tick on the 1 that precedes the 18-zero run.
        st    = 19'h40000;
        ticks = 0;
        for (int i = 0; i < 600000 && ticks < 2; i++) begin
            mt = (st == 19'h40000);
            if (mt) ticks++;
            drive(1'b1, st[18], mt, 1'b0);
            st = {st[17:0], st[18] ^ st[17] ^ st[16] ^ st[13]};
        end
        check("lfsr_ticks", 64'(ticks), 64'd2);
        lit("lfsr", 262144, 19, 18, 524287, 1, 0);
        check("lfsr_s_period_len", 64'(bus_s.period_len), 64'd7);

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
